wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue_pkg.sv | 13 +
 rtl/wb_queue_if.sv | 39 +++
 rtl/wb_queue_match.sv | 30 +++
 rtl/wb_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// Shared types for the write-back queue: register/data widths and the queued entry record.
package wb_queue_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle between the write-back queue, its producer and the register file.
interface wb_queue_if #(parameter int DEPTH = 4);
  import wb_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] in_reg;
  logic [DATA_W-1:0]    in_data;
  logic                 wr_stall;
  logic                 RegWrite;
  logic [REG_IDX_W-1:0] WriteRegister;
  logic [DATA_W-1:0]    WriteData;
  logic [REG_IDX_W-1:0] ReadRegister1;
  logic [REG_IDX_W-1:0] ReadRegister2;
  logic [DATA_W-1:0]    rf_rdata1;
  logic [DATA_W-1:0]    rf_rdata2;
  logic [DATA_W-1:0]    ReadData1;
  logic [DATA_W-1:0]    ReadData2;
  logic                 pending1;
  logic                 pending2;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, in_reg, in_data, wr_stall,
    output ReadRegister1, ReadRegister2, rf_rdata1, rf_rdata2,
    input  in_ready, RegWrite, WriteRegister, WriteData,
    input  ReadData1, ReadData2, pending1, pending2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wr_stall,
    input  ReadRegister1, ReadRegister2, rf_rdata1, rf_rdata2,
    output in_ready, RegWrite, WriteRegister, WriteData,
    output ReadData1, ReadData2, pending1, pending2, count
  );

endinterface

// File: rtl/wb_queue_match.sv
// wb_match: combinational search of the queue for the youngest valid entry matching one read index.
module wb_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [REG_IDX_W-1:0]         rd,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int PTR_W = $clog2(DEPTH);

  // NOTE: every output gets a default before the loop so no latch is inferred;
  // walking oldest-to-youngest lets the last match win, i.e. the youngest entry.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[head + PTR_W'(i)].valid && (rd != '0) &&
          (entries[head + PTR_W'(i)].reg_idx == rd)) begin
        hit  = 1'b1;
        data = entries[head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers register-file writes while the write port is stalled and keeps
// reads coherent. Define WB_QUEUE_BYPASS_EN to forward queued data onto ReadData1/2.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  wb_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               not_empty;
  logic               enq;
  logic               deq;

  assign not_empty = (count != '0);
  // No pass-through when full: a same-cycle drain does not open a slot.
  assign bus.in_ready = (count < CNT_W'(DEPTH));
  assign enq = bus.in_valid && bus.in_ready && (bus.in_reg != '0);
  assign deq = not_empty && !bus.wr_stall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only the valid bits are reset; payload fields are don't-care until written.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (enq) begin
        entries[tail] <= '{valid: 1'b1, reg_idx: bus.in_reg, data: bus.in_data};
        tail          <= tail + 1'b1;
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  assign bus.RegWrite      = deq;
  assign bus.WriteRegister = not_empty ? entries[head].reg_idx : '0;
  assign bus.WriteData     = not_empty ? entries[head].data    : '0;
  assign bus.count         = count;

  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] mdata1;
  logic [DATA_W-1:0] mdata2;

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries),
    .head    (head),
    .rd      (bus.ReadRegister1),
    .hit     (hit1),
    .data    (mdata1)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries),
    .head    (head),
    .rd      (bus.ReadRegister2),
    .hit     (hit2),
    .data    (mdata2)
  );

  assign bus.pending1 = hit1;
  assign bus.pending2 = hit2;

`ifdef WB_QUEUE_BYPASS_EN
  assign bus.ReadData1 = (bus.ReadRegister1 == '0) ? '0 : (hit1 ? mdata1 : bus.rf_rdata1);
  assign bus.ReadData2 = (bus.ReadRegister2 == '0) ? '0 : (hit2 ? mdata2 : bus.rf_rdata2);
`else
  // Without forwarding the consumer relies on pending1/2 to stall.
  logic unused_bypass;
  assign unused_bypass = ^{mdata1, mdata2};
  assign bus.ReadData1 = (bus.ReadRegister1 == '0) ? '0 : bus.rf_rdata1;
  assign bus.ReadData2 = (bus.ReadRegister2 == '0) ? '0 : bus.rf_rdata2;
`endif

endmodule
